// File: rtl/ftoi_converter_pipe.sv
// Float-to-integer converter with a 2-stage pipeline: S1 classifies and
// align-shifts, S2 rounds, negates, range-checks and saturates.
// Latency: 2 cycles from accept to valid_out. Backpressure: a stalled output
// holds its result, S1 fills behind it, and then ready_out drops.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   valid_in / ready_out       operand handshake (ready_out also needs a convert op)
//   valid_out / ready_in       result handshake
//   op, rm, wsel               operation, rounding mode, 32-bit result select
//   man, Exp, sgn, zero, inf,  operand significand (with hidden bit), biased
//   sNaN, qNaN                 exponent, sign and class flags
//   int_out, IV, IE            registered result, invalid and inexact flags
module ftoi_converter_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             valid_out,
  input  logic             ready_in,
  input  logic [4:0]       op,
  input  logic [2:0]       rm,
  input  logic             wsel,
  input  logic [MAN_W:0]   man,
  input  logic [EXP_W-1:0] Exp,
  input  logic             sgn,
  input  logic             zero,
  input  logic             inf,
  input  logic             sNaN,
  input  logic             qNaN,
  output logic [INT_W-1:0] int_out,
  output logic             IV,
  output logic             IE
);

  // Operation codes shared with the FPU op decoder.
  localparam logic [4:0] FPU_OP_CVTFI = 5'd8;
  localparam logic [4:0] FPU_OP_CVTFU = 5'd9;

  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
  // Largest biased exponent whose magnitude still fits in INT_W bits.
  localparam int EXP_LIM = BIAS + INT_W - 1;
  // Alignment frame: INT_W integer bits, one guard bit, MAN_W+1 sticky bits.
  localparam int VW      = INT_W + MAN_W + 2;
  localparam logic [INT_W:0] ONE = {{INT_W{1'b0}}, 1'b1};

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  logic s1_vld;
  logic op_ok;
  logic s2_adv;
  logic accept;

  assign op_ok     = (op == FPU_OP_CVTFI) || (op == FPU_OP_CVTFU);
  assign s2_adv    = !valid_out || ready_in;
  assign ready_out = op_ok && (!s1_vld || s2_adv);
  assign accept    = valid_in && ready_out;

  // ------------------------------------------------------------------
  // Stage 1: alignment
  // ------------------------------------------------------------------
  logic [31:0]     exp_ext;
  logic [31:0]     sh_amt;
  logic            big_c;
  logic [VW-1:0]   x0;
  logic [2*VW-1:0] dbl;

  always_comb begin
    exp_ext = 32'(Exp);
    big_c   = exp_ext > 32'(EXP_LIM);
    sh_amt  = big_c ? 32'd0 : (32'(EXP_LIM) - exp_ext);
    // Clamping at VW pushes every significand bit into the lower half,
    // where it only feeds sticky, so tiny operands need no special case.
    if (sh_amt > 32'(VW))
      sh_amt = 32'(VW);
    // Significand MSB sits at weight 2^(INT_W-1) before the shift.
    x0  = {man, {(INT_W + 1){1'b0}}};
    dbl = {x0, {VW{1'b0}}} >> sh_amt;
  end

  logic [INT_W-1:0] s1_mag;
  logic             s1_g, s1_s;
  logic             s1_sgn, s1_uns, s1_w32;
  logic [2:0]       s1_rm;
  logic             s1_nan, s1_inf, s1_zero, s1_big;

  // Datapath registers need no reset; s1_vld qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_mag  <= dbl[2*VW-1 -: INT_W];
      s1_g    <= dbl[VW + MAN_W + 1];
      s1_s    <= |dbl[VW + MAN_W:0];
      s1_sgn  <= sgn;
      s1_uns  <= (op == FPU_OP_CVTFU);
      s1_w32  <= (INT_W == 32) || wsel;
      s1_rm   <= rm;
      s1_nan  <= sNaN | qNaN;
      s1_inf  <= inf;
      s1_zero <= zero;
      s1_big  <= big_c;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: round, range-check, saturate
  // ------------------------------------------------------------------
  logic             inexact, inc, in_rng;
  logic [INT_W:0]   rmag, lim_s, lim_u, val, tmp_max_s, tmp_min_s, tmp_max_u;
  logic [INT_W-1:0] sat_pos, sat_neg, res_c;
  logic             iv_c, ie_c;

  always_comb begin
    inexact = s1_g | s1_s;
    case (s1_rm)
      3'b000:  inc = s1_g & (s1_s | s1_mag[0]);   // nearest, ties to even
      3'b010:  inc = s1_sgn & inexact;            // toward -inf
      3'b011:  inc = ~s1_sgn & inexact;           // toward +inf
      3'b100:  inc = s1_g;                        // nearest, ties away
      default: inc = 1'b0;                        // toward zero
    endcase
    rmag = {1'b0, s1_mag} + {{INT_W{1'b0}}, inc};

    // lim_s = 2^(R-1), lim_u = 2^R for the selected result width R.
    lim_s = s1_w32 ? (ONE << 31) : (ONE << (INT_W - 1));
    lim_u = s1_w32 ? (ONE << 32) : (ONE << INT_W);
    tmp_max_s = lim_s - ONE;
    tmp_min_s = ~lim_s + ONE;
    tmp_max_u = lim_u - ONE;
    sat_pos = s1_uns ? tmp_max_u[INT_W-1:0] : tmp_max_s[INT_W-1:0];
    sat_neg = s1_uns ? '0 : tmp_min_s[INT_W-1:0];

    in_rng = 1'b0;
    val    = '0;
    iv_c   = 1'b0;
    ie_c   = 1'b0;
    res_c  = '0;
    if (s1_nan) begin
      iv_c  = 1'b1;
      res_c = sat_pos;
    end else if (s1_inf) begin
      iv_c  = 1'b1;
      res_c = s1_sgn ? sat_neg : sat_pos;
    end else if (!s1_zero) begin
      if (s1_uns)
        in_rng = !s1_big && (s1_sgn ? (rmag == '0) : (rmag < lim_u));
      else
        in_rng = !s1_big && (s1_sgn ? (rmag <= lim_s) : (rmag < lim_s));
      if (in_rng) begin
        val   = s1_sgn ? (~rmag + ONE) : rmag;
        res_c = val[INT_W-1:0];
        ie_c  = inexact;
      end else begin
        iv_c  = 1'b1;
        res_c = s1_sgn ? sat_neg : sat_pos;
      end
    end

    // 32-bit results are sign-extended from bit 31, unsigned ones included.
    if (s1_w32) begin
      for (int i = 32; i < INT_W; i++)
        res_c[i] = res_c[31];
    end
  end

  // ------------------------------------------------------------------
  // Valids and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      valid_out <= 1'b0;
      int_out   <= '0;
      IV        <= 1'b0;
      IE        <= 1'b0;
    end else begin
      if (accept)
        s1_vld <= 1'b1;
      else if (s2_adv)
        s1_vld <= 1'b0;

      if (s2_adv) begin
        valid_out <= s1_vld;
        if (s1_vld) begin
          int_out <= res_c;
          IV      <= iv_c;
          IE      <= ie_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_ftoi_converter_pipe.sv
// Bench for ftoi_converter_pipe (INT_W=64; wsel=1 covers the 32-bit results).
// Expected results come from an exact-arithmetic reference model and are
// queued at accept time, then compared in order as results leave the DUT.
module tb_ftoi_converter_pipe;

  localparam logic [4:0] OP_I = 5'd8;
  localparam logic [4:0] OP_U = 5'd9;

  logic        clk = 1'b0;
  logic        reset, valid_in, ready_out, valid_out, ready_in;
  logic [4:0]  op;
  logic [2:0]  rm;
  logic        wsel;
  logic [23:0] man;
  logic [7:0]  Exp;
  logic        sgn, zero, inf, sNaN, qNaN;
  logic [63:0] int_out;
  logic        IV, IE;

  typedef struct packed {
    logic [63:0] res;
    logic        iv;
    logic        ie;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done;

  always #5 clk = ~clk;

  ftoi_converter_pipe #(.EXP_W(8), .MAN_W(23), .INT_W(64)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .valid_out(valid_out), .ready_in(ready_in), .op(op), .rm(rm), .wsel(wsel),
    .man(man), .Exp(Exp), .sgn(sgn), .zero(zero), .inf(inf), .sNaN(sNaN),
    .qNaN(qNaN), .int_out(int_out), .IV(IV), .IE(IE)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Exact model: integer part and remainder, rounding by comparing the
  // remainder against one half.
  function automatic exp_t model(input logic [4:0] f_op, input logic [2:0] f_rm,
                                 input logic f_w, input logic [23:0] f_man,
                                 input logic [7:0] f_exp, input logic f_sgn,
                                 input logic f_zero, input logic f_inf, input logic f_nan);
    exp_t r;
    logic uns, inexact, up, ok, big;
    int rw, e, k;
    logic [127:0] ip, rem, half, lim, smax, smin, umax, v;
    uns  = (f_op == OP_U);
    rw   = f_w ? 32 : 64;
    lim  = 128'd1 << (rw - 1);
    smax = lim - 128'd1;
    smin = ~lim + 128'd1;
    umax = (128'd1 << rw) - 128'd1;
    r = '0; ok = 1'b1; inexact = 1'b0; up = 1'b0; big = 1'b0;
    ip = '0; rem = '0; half = '0; v = '0;
    e = int'(f_exp) - 127;
    if (f_nan) begin
      r.iv = 1'b1;
      v = uns ? umax : smax;
    end else if (f_inf) begin
      r.iv = 1'b1;
      v = f_sgn ? (uns ? '0 : smin) : (uns ? umax : smax);
    end else if (!f_zero) begin
      if (e >= 70) big = 1'b1;
      else if (e >= 23) ip = 128'(f_man) << (e - 23);
      else begin
        k = 23 - e;
        if (k > 100) begin
          rem  = 128'(f_man);
          half = 128'd1 << 100;
        end else begin
          ip   = 128'(f_man) >> k;
          rem  = 128'(f_man) & ((128'd1 << k) - 128'd1);
          half = 128'd1 << (k - 1);
        end
      end
      inexact = (rem != '0);
      case (f_rm)
        3'd0:    up = (rem > half) || ((rem == half) && ip[0]);
        3'd2:    up = f_sgn && inexact;
        3'd3:    up = !f_sgn && inexact;
        3'd4:    up = (rem >= half) && inexact;
        default: up = 1'b0;
      endcase
      ip = ip + 128'(up);
      if (big)      ok = 1'b0;
      else if (uns) ok = f_sgn ? (ip == '0) : (ip <= umax);
      else          ok = f_sgn ? (ip <= lim) : (ip <= smax);
      if (ok) begin
        v = f_sgn ? (~ip + 128'd1) : ip;
        r.ie = inexact;
      end else begin
        r.iv = 1'b1;
        v = f_sgn ? (uns ? '0 : smin) : (uns ? umax : smax);
      end
    end
    r.res = v[63:0];
    if (f_w) r.res[63:32] = {32{v[31]}};
    return r;
  endfunction

  task automatic send(input logic [4:0] s_op, input logic [2:0] s_rm, input logic s_w,
                      input logic [23:0] s_man, input logic [7:0] s_exp, input logic s_sgn,
                      input logic s_zero, input logic s_inf, input logic s_snan, input logic s_qnan);
    logic took;
    took = 1'b0;
    op = s_op; rm = s_rm; wsel = s_w; man = s_man; Exp = s_exp; sgn = s_sgn;
    zero = s_zero; inf = s_inf; sNaN = s_snan; qNaN = s_qnan;
    valid_in = 1'b1;
    for (int i = 0; i < 100 && !took; i++) begin
      @(negedge clk);
      took = ready_out;
      @(posedge clk);
    end
    if (took)
      sb_q.push_back(model(s_op, s_rm, s_w, s_man, s_exp, s_sgn, s_zero, s_inf, s_snan | s_qnan));
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: ready_out low for 100 cycles, required 1");
    end
    #1 valid_in = 1'b0;
  endtask

  // Scoreboard: compares the queue head whenever a result is presented,
  // so stalled results are re-checked every cycle they are held.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got result %h, required no result", int_out);
      end else begin
        mon_e = sb_q[0];
        check("int_out", int_out, mon_e.res);
        check("IV", IV, mon_e.iv);
        check("IE", IE, mon_e.ie);
        if (ready_in) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b1; op = OP_I; rm = 3'd0; wsel = 1'b0;
    man = '0; Exp = '0; sgn = 1'b0; zero = 1'b0; inf = 1'b0; sNaN = 1'b0; qNaN = 1'b0;
    done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_int_out", int_out, 64'd0);
    check("rst_IV", IV, 1'b0);
    check("rst_IE", IE, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", ready_out, 1'b1);

    // Unsupported op is never accepted.
    op = 5'd3; valid_in = 1'b1;
    #1 check("ready_bad_op", ready_out, 1'b0);
    @(posedge clk); #1 valid_in = 1'b0;

    // 2.5 RNE with latency check, then directed corner cases back to back.
    send(OP_I, 3'd0, 1'b1, 24'hA00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("latency_c1", valid_out, 1'b0);
    @(negedge clk); check("latency_c2", valid_out, 1'b1);
    @(posedge clk); #1;
    send(OP_I, 3'd4, 1'b1, 24'hA00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 2.5 RMM
    send(OP_I, 3'd5, 1'b1, 24'hA00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // rm 5 -> RTZ
    send(OP_I, 3'd0, 1'b1, 24'hE00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 3.5 RNE tie
    send(OP_U, 3'd1, 1'b1, 24'hC00000, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // -0.75 RTZ
    send(OP_U, 3'd0, 1'b1, 24'hC00000, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // -0.75 RNE
    send(OP_I, 3'd0, 1'b1, 24'h800000, 8'h9E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 2^31
    send(OP_I, 3'd0, 1'b1, 24'h800000, 8'h9E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // -2^31
    send(OP_I, 3'd0, 1'b1, 24'hC00000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // qNaN
    send(OP_I, 3'd0, 1'b0, 24'h800000, 8'hA7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 2^40
    send(OP_I, 3'd0, 1'b1, 24'h800000, 8'hA7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 2^40 wsel
    send(OP_U, 3'd0, 1'b1, 24'h800000, 8'h9F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 2^32 wsel
    send(OP_U, 3'd0, 1'b1, 24'hB2D05E, 8'h9E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 3e9 wsel
    send(OP_I, 3'd0, 1'b0, 24'h000000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // -0
    send(OP_U, 3'd0, 1'b0, 24'h800000, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // +inf
    send(OP_I, 3'd0, 1'b0, 24'h800000, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // -inf
    send(OP_U, 3'd0, 1'b0, 24'hC00001, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // sNaN
    send(OP_I, 3'd3, 1'b0, 24'h400000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // subnormal RUP
    send(OP_I, 3'd2, 1'b0, 24'h400000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // -subnormal RDN
    send(OP_U, 3'd0, 1'b0, 24'h800000, 8'hBE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 2^63 unsigned
    send(OP_I, 3'd0, 1'b0, 24'h800000, 8'hBE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // 2^63 signed
    send(OP_I, 3'd0, 1'b0, 24'h800000, 8'hBE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // -2^63

    // Five back-to-back operands while the output is stalled for 4 cycles.
    ready_in = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(OP_I, 3'd0, 1'b0, 24'h800000, 8'(127 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        check("ready_drop_full", ready_out, 1'b0);
        repeat (2) @(posedge clk);
        #1 ready_in = 1'b1;
      end
    join

    // Reset with two operands in flight: both must vanish.
    repeat (4) @(posedge clk);
    #1 ready_in = 1'b0;
    send(OP_I, 3'd0, 1'b1, 24'hA00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(OP_I, 3'd0, 1'b1, 24'hE00000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid_out", valid_out, 1'b0);
    check("midrst_int_out", int_out, 64'd0);
    check("midrst_IV", IV, 1'b0);
    check("midrst_IE", IE, 1'b0);
    @(posedge clk); #1 reset = 1'b0; ready_in = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("no_stale_result", valid_out, 1'b0);

    // Random operands under random output backpressure.
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          send(($urandom_range(1) != 0) ? OP_U : OP_I, 3'($urandom_range(7)),
               1'($urandom_range(1)), {1'b1, 23'($urandom)}, 8'($urandom_range(110, 195)),
               1'($urandom_range(1)), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 ready_in = ($urandom_range(3) != 0);
        end
        ready_in = 1'b1;
      end
    join

    ready_in = 1'b1;
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    #1 check("drain_queue_empty", sb_q.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
